// File: rtl/nco_voice_scheduler_if.sv
// nco_voice_scheduler_if: shared sine ROM read port (request/address out, data back ROM_LAT cycles later)
interface nco_voice_scheduler_if #(
  parameter int ADDR_W = 8,
  parameter int SAMPLE_W = 24
);
  logic rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic [SAMPLE_W-1:0] rom_data;
  modport master (output rom_req, rom_addr, input rom_data);
  modport slave (input rom_req, rom_addr, output rom_data);
endinterface

// File: rtl/nco_voice_scheduler.sv
// nco_voice_scheduler: steps NUM_VOICES NCO phase accumulators per 96 kHz tick through one shared sine ROM and mixes them.
// Define NCO_SAT_EN to saturate the full mix; otherwise the mix is scaled by 1/NUM_VOICES.
module nco_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int ACC_W = 16,
  parameter int ADDR_W = 8,
  parameter int STEP_W = 16,
  parameter int SAMPLE_W = 24,
  parameter int ROM_LAT = 2
) (
  input  logic clk_100M,
  input  logic resetn,
  input  logic clk_96k,
  input  logic cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic cfg_enable,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [ADDR_W-1:0] cfg_phase,
  nco_voice_scheduler_if.master rom,
  output logic [SAMPLE_W-1:0] sample,
  output logic sample_valid,
  output logic busy,
  output logic overrun,
  output logic [$clog2(NUM_VOICES):0] active_voices
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int MW = SAMPLE_W + VW;
  localparam int CW = $clog2(NUM_VOICES + ROM_LAT);
  localparam logic [CW-1:0] LAST_V = CW'(NUM_VOICES - 1);
  localparam logic [CW-1:0] LAST_D = CW'(ROM_LAT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;
  state_t state;
  logic q, qq, tick;
  logic [CW-1:0] cnt;
  logic [VW-1:0] v, nv;
  logic [NUM_VOICES-1:0] sh_en, en, n_en;
  logic [STEP_W-1:0] sh_step [NUM_VOICES];
  logic [STEP_W-1:0] step [NUM_VOICES];
  logic [STEP_W-1:0] n_step [NUM_VOICES];
  logic [ADDR_W-1:0] sh_phase [NUM_VOICES];
  logic [ADDR_W-1:0] phase [NUM_VOICES];
  logic [ADDR_W-1:0] n_phase [NUM_VOICES];
  logic [ACC_W-1:0] acc [NUM_VOICES];
  logic [ROM_LAT-1:0] vld;
  logic signed [MW-1:0] mix, mix_nxt, ret;
  logic [SAMPLE_W-1:0] mixed_out;
  logic issue_next;
  assign tick = q & ~qq;
  assign v = cnt[VW-1:0];
  assign nv = v + 1'b1;
  assign busy = state != IDLE;
  assign ret = MW'(signed'(rom.rom_data));
  assign mix_nxt = vld[ROM_LAT-1] ? mix + ret : mix;
  assign issue_next = cnt != LAST_V && en[nv];
  // Shadow view including a same-cycle write, so a write on the tick cycle joins that commit
  always_comb begin
    active_voices = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      n_en[i] = cfg_we && cfg_voice == VW'(i) ? cfg_enable : sh_en[i];
      n_step[i] = cfg_we && cfg_voice == VW'(i) ? cfg_step : sh_step[i];
      n_phase[i] = cfg_we && cfg_voice == VW'(i) ? cfg_phase : sh_phase[i];
      active_voices = active_voices + (VW + 1)'(en[i]);
    end
  end
`ifdef NCO_SAT_EN
  localparam logic signed [MW-1:0] SMAX = {{(VW + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [MW-1:0] SMIN = ~SMAX;
  assign mixed_out = mix_nxt > SMAX ? SAMPLE_W'(SMAX) : mix_nxt < SMIN ? SAMPLE_W'(SMIN) : SAMPLE_W'(mix_nxt);
`else
  assign mixed_out = SAMPLE_W'(mix_nxt >>> VW);
`endif
  // ROM request/address are registered one cycle ahead so they line up with the voice's ISSUE cycle
  always_ff @(posedge clk_100M) begin
    if (!resetn) begin
      state <= IDLE;
      q <= 1'b0;
      qq <= 1'b0;
      cnt <= '0;
      sh_en <= '0;
      en <= '0;
      vld <= '0;
      mix <= '0;
      sample <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
      rom.rom_req <= 1'b0;
      rom.rom_addr <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        sh_step[i] <= '0;
        step[i] <= '0;
        sh_phase[i] <= '0;
        phase[i] <= '0;
        acc[i] <= '0;
      end
    end else begin
      q <= clk_96k;
      qq <= q;
      vld <= ROM_LAT'({vld, rom.rom_req});
      mix <= mix_nxt;
      sample_valid <= 1'b0;
      if (cfg_we) begin
        sh_en[cfg_voice] <= cfg_enable;
        sh_step[cfg_voice] <= cfg_step;
        sh_phase[cfg_voice] <= cfg_phase;
      end
      if (tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          en <= n_en;
          step <= n_step;
          phase <= n_phase;
          mix <= '0;
          cnt <= '0;
          rom.rom_req <= n_en[0];
          if (n_en[0]) rom.rom_addr <= acc[0][ACC_W-1 -: ADDR_W] + n_phase[0];
          state <= ISSUE;
        end
        ISSUE: begin
          acc[v] <= en[v] ? acc[v] + ACC_W'(step[v]) : '0;
          rom.rom_req <= issue_next;
          if (issue_next) rom.rom_addr <= acc[nv][ACC_W-1 -: ADDR_W] + phase[nv];
          cnt <= cnt == LAST_V ? '0 : cnt + 1'b1;
          state <= cnt == LAST_V ? DRAIN : ISSUE;
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_D) begin
            sample <= mixed_out;
            sample_valid <= 1'b1;
            state <= OUTPUT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
